// File: rtl/ro_trng_pkg.sv
// Shared types and default constants for the ring-oscillator TRNG controller.
//   state_e : controller FSM states
//   Def*    : default parameter values
//   cnt_w() : counter width for a counter whose terminal count is limit-1 (minimum 1 bit)
package ro_trng_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWarmup,
    StSample,
    StHold,
    StFault
  } state_e;

  localparam int unsigned DefNumRo     = 4;
  localparam int unsigned DefWarmup    = 16;
  localparam int unsigned DefSampleDiv = 8;
  localparam int unsigned DefWordW     = 8;
  localparam int unsigned DefRepLimit  = 16;

  function automatic int unsigned cnt_w(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/ro_health_rep.sv
// Repetition-count health tester for the sampled TRNG bit stream.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   strobe_i : a new sampled bit is present on bit_i
//   bit_i    : sampled bit
//   clear_i  : restart the run (next strobed bit counts as 1)
//   fail_o   : combinational pulse when a strobed bit makes the run reach REP_LIMIT
module ro_health_rep
  import ro_trng_pkg::*;
#(
  parameter int unsigned REP_LIMIT = DefRepLimit
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_i,
  input  logic bit_i,
  input  logic clear_i,
  output logic fail_o
);

  localparam int unsigned CntW = cnt_w(REP_LIMIT);
  // The count never needs to hold REP_LIMIT itself: the strobe that would reach it fails instead.
  localparam logic [CntW-1:0] CntLast = CntW'(REP_LIMIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    fail_o = 1'b0;
    if (clear_i) begin
      cnt_d  = '0;
      last_d = 1'b0;
    end else if (strobe_i) begin
      last_d = bit_i;
      // cnt_q == 0 marks "no bit seen yet", so the first bit always starts a run of 1.
      if ((cnt_q == '0) || (bit_i != last_q)) begin
        cnt_d = CntW'(1);
      end else if (cnt_q == CntLast) begin
        fail_o = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ro_trng_ctrl.sv
// Ring-oscillator TRNG controller: starts/stops the oscillator bank, waits a warm-up period,
// samples the XOR of all oscillator outputs every SAMPLE_DIV cycles, packs WORD_W bits per word
// onto a valid/ready output and runs a repetition-count health test with a sticky fault.
//   clock, reset : clock and synchronous active-high reset
//   start, stop  : one-cycle requests to begin / halt generation (stop wins)
//   ro_enable    : per-oscillator hold, 1 = stopped, 0 = running
//   ro_bits      : registered oscillator outputs
//   out_data, out_valid, out_ready : output word handshake
//   busy         : warming up, sampling or holding a completed word
//   health_fail  : sticky repetition-count fault
module ro_trng_ctrl
  import ro_trng_pkg::*;
#(
  parameter int unsigned NUM_RO     = DefNumRo,
  parameter int unsigned WARMUP     = DefWarmup,
  parameter int unsigned SAMPLE_DIV = DefSampleDiv,
  parameter int unsigned WORD_W     = DefWordW,
  parameter int unsigned REP_LIMIT  = DefRepLimit
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [NUM_RO-1:0] ro_enable,
  input  logic [NUM_RO-1:0] ro_bits,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              health_fail
);

  localparam int unsigned WarmW = cnt_w(WARMUP);
  localparam int unsigned DivW  = cnt_w(SAMPLE_DIV);
  localparam int unsigned BitW  = cnt_w(WORD_W);

  localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP - 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(SAMPLE_DIV - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WORD_W - 1);

  state_e              state_q, state_d;
  logic [WarmW-1:0]    warm_q, warm_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [BitW-1:0]     bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                fail_q, fail_d;
  logic [NUM_RO-1:0]   ro_en_q, ro_en_d;

  logic              accept;
  logic              out_free;
  logic              strobe;
  logic              samp_bit;
  logic [WORD_W-1:0] word_next;
  logic              health_strobe;
  logic              health_clear;
  logic              rep_fail;

  assign accept    = valid_q & out_ready;
  assign out_free  = ~valid_q | accept;
  assign strobe    = (state_q == StSample) && (div_q == DivLast);
  assign samp_bit  = ^ro_bits;
  assign word_next = {shreg_q[WORD_W-2:0], samp_bit};

  // A strobe coinciding with stop is discarded, so it must not feed the health run either.
  assign health_strobe = strobe & ~stop;
  assign health_clear  = (state_q == StIdle) || (state_q == StWarmup);

  ro_health_rep #(
    .REP_LIMIT(REP_LIMIT)
  ) u_health (
    .clk_i   (clock),
    .rst_i   (reset),
    .strobe_i(health_strobe),
    .bit_i   (samp_bit),
    .clear_i (health_clear),
    .fail_o  (rep_fail)
  );

  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    div_d    = div_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    valid_d  = valid_q & ~accept;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StWarmup;
          warm_d  = '0;
        end
      end

      StWarmup: begin
        if (stop) begin
          state_d = StIdle;
          warm_d  = '0;
        end else if (warm_q == WarmLast) begin
          state_d = StSample;
          warm_d  = '0;
          div_d   = '0;
        end else begin
          warm_d = warm_q + 1'b1;
        end
      end

      StSample: begin
        if (stop) begin
          state_d  = StIdle;
          div_d    = '0;
          bitcnt_d = '0;
          shreg_d  = '0;
        end else if (rep_fail) begin
          state_d  = StFault;
          valid_d  = 1'b0;
          div_d    = '0;
          bitcnt_d = '0;
          shreg_d  = '0;
        end else begin
          div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
          if (strobe) begin
            shreg_d = word_next;
            if (bitcnt_q == BitLast) begin
              bitcnt_d = '0;
              if (out_free) begin
                data_d  = word_next;
                valid_d = 1'b1;
              end else begin
                state_d = StHold;
              end
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end
      end

      StHold: begin
        if (stop) begin
          state_d = StIdle;
          shreg_d = '0;
        end else if (out_free) begin
          state_d = StSample;
          data_d  = shreg_q;
          valid_d = 1'b1;
          div_d   = '0;
        end
      end

      StFault: begin
        valid_d = 1'b0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d  = (state_d == StWarmup) || (state_d == StSample) || (state_d == StHold);
    ro_en_d = {NUM_RO{~busy_d}};
    fail_d  = (state_d == StFault);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      warm_q   <= '0;
      div_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      fail_q   <= 1'b0;
      ro_en_q  <= '1;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      fail_q   <= fail_d;
      ro_en_q  <= ro_en_d;
    end
  end

  assign ro_enable   = ro_en_q;
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign busy        = busy_q;
  assign health_fail = fail_q;

endmodule

// File: tb/tb_ro_trng_ctrl.sv
// Self-checking bench for ro_trng_ctrl: table-driven directed sequences plus a randomized run
// checked against a behavioural model of the sampled bit stream.
module tb_ro_trng_ctrl;
  import ro_trng_pkg::*;

  localparam int unsigned NR = DefNumRo;
  localparam int unsigned WU = DefWarmup;
  localparam int unsigned SD = DefSampleDiv;
  localparam int unsigned WW = DefWordW;
  localparam int unsigned RL = DefRepLimit;

  logic          clock;
  logic          reset;
  logic          start;
  logic          stop;
  logic [NR-1:0] ro_enable;
  logic [NR-1:0] ro_bits;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          health_fail;

  ro_trng_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .ro_enable  (ro_enable),
    .ro_bits    (ro_bits),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .health_fail(health_fail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int            cyc;
    logic [NR-1:0] en;
    logic          valid;
    logic [WW-1:0] data;
    logic          busy;
    logic          fail;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input int c, input logic [NR-1:0] en, input logic v,
                              input logic [WW-1:0] d, input logic b, input logic f);
    vec_t r;
    r.cyc = c; r.en = en; r.valid = v; r.data = d; r.busy = b; r.fail = f;
    return r;
  endfunction

  task automatic check_vec(input string name, input vec_t v);
    chk({name, ".ro_enable"}, 64'(ro_enable), 64'(v.en));
    chk({name, ".out_valid"}, 64'(out_valid), 64'(v.valid));
    chk({name, ".out_data"}, 64'(out_data), 64'(v.data));
    chk({name, ".busy"}, 64'(busy), 64'(v.busy));
    chk({name, ".health_fail"}, 64'(health_fail), 64'(v.fail));
  endtask

  // Random oscillator outputs whose XOR equals b.
  function automatic logic [NR-1:0] enc(input logic b);
    logic [NR-1:0] r;
    r    = NR'($urandom);
    r[0] = b ^ (^r[NR-1:1]);
    return r;
  endfunction

  // Bit sampled by strobe k (k-th window after warm-up) is st[15-k]; zero outside.
  function automatic logic stream_bit(input int c, input logic [15:0] st);
    int k;
    k = c - int'(WU) - 1;
    if (k < 0) return 1'b0;
    k = k / int'(SD);
    if (k > 15) return 1'b0;
    return st[15-k];
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    out_ready = 1'b0;
    ro_bits   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Start at local cycle 0, optional stop, ready window [rdy_from, rdy_to); check tbl entries.
  task automatic run_seq(input string name, input int last, input logic [15:0] st,
                         input int stop_at, input int rdy_from, input int rdy_to);
    for (int c = 0; c <= last; c++) begin
      if (c > 0) tick();
      cyc       = c;
      start     = (c == 0);
      stop      = (c == stop_at);
      out_ready = (c >= rdy_from) && (c < rdy_to);
      ro_bits   = enc(stream_bit(c, st));
      foreach (tbl[i]) if (tbl[i].cyc == c) check_vec(name, tbl[i]);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic run_random(input int n);
    int            mode;  // 0 idle, 1 running, 2 fault
    logic          m_valid;
    logic [WW-1:0] m_data;
    int            cd;    // cycles until the next sampling instant
    int            run_len;
    logic          last_b;
    logic [WW-1:0] acc;
    int            nacc;
    logic          holding;
    logic [WW-1:0] hword;
    logic          acc_ok, free, nv, b;
    mode = 0; m_valid = 1'b0; m_data = '0; cd = 0; run_len = 0; last_b = 1'b0;
    acc = '0; nacc = 0; holding = 1'b0; hword = '0;
    for (int c = 0; c < n; c++) begin
      if (c > 0) tick();
      cyc       = c;
      start     = ($urandom_range(0, 19) == 0);
      stop      = ($urandom_range(0, 399) == 0);
      out_ready = 1'($urandom_range(0, 1));
      ro_bits   = NR'($urandom);

      chk("rand.out_valid", 64'(out_valid), 64'(m_valid));
      chk("rand.out_data", 64'(out_data), 64'(m_data));
      chk("rand.busy", 64'(busy), 64'(mode == 1));
      chk("rand.health_fail", 64'(health_fail), 64'(mode == 2));
      chk("rand.ro_enable", 64'(ro_enable), (mode == 1) ? 64'(0) : 64'({NR{1'b1}}));

      acc_ok = m_valid && out_ready;
      free   = !m_valid || acc_ok;
      nv     = m_valid && !acc_ok;
      case (mode)
        0: begin
          if (start && !stop) begin
            mode = 1; cd = int'(WU + SD) - 1; run_len = 0; nacc = 0; acc = '0; holding = 1'b0;
          end
        end
        1: begin
          if (stop) begin
            mode = 0;
          end else if (holding) begin
            if (free) begin
              m_data = hword; nv = 1'b1; holding = 1'b0; cd = int'(SD) - 1;
            end
          end else if (cd == 0) begin
            b       = ^ro_bits;
            run_len = (run_len > 0 && b == last_b) ? run_len + 1 : 1;
            last_b  = b;
            cd      = int'(SD) - 1;
            if (run_len >= int'(RL)) begin
              mode = 2; nv = 1'b0;
            end else begin
              acc = {acc[WW-2:0], b};
              nacc++;
              if (nacc == int'(WW)) begin
                nacc = 0;
                if (free) begin
                  m_data = acc; nv = 1'b1;
                end else begin
                  holding = 1'b1; hword = acc;
                end
              end
            end
          end else begin
            cd--;
          end
        end
        default: nv = 1'b0;
      endcase
      m_valid = nv;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values.
    do_reset();
    check_vec("reset", mk(0, '1, 1'b0, '0, 1'b0, 1'b0));

    // 1: alternating bits, always ready.
    tbl.delete();
    tbl.push_back(mk(0,   '1, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1,   '0, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(80,  '0, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(81,  '0, 1'b1, 8'hAA, 1'b1, 1'b0));
    tbl.push_back(mk(82,  '0, 1'b0, 8'hAA, 1'b1, 1'b0));
    tbl.push_back(mk(144, '0, 1'b0, 8'hAA, 1'b1, 1'b0));
    tbl.push_back(mk(145, '0, 1'b1, 8'hAA, 1'b1, 1'b0));
    run_seq("t1", 145, 16'hAAAA, -1, 0, 1 << 30);

    // 2: consumer stalled until cycle 200; second word held then released.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(81,  '0, 1'b1, 8'hAA, 1'b1, 1'b0));
    tbl.push_back(mk(150, '0, 1'b1, 8'hAA, 1'b1, 1'b0));
    tbl.push_back(mk(200, '0, 1'b1, 8'hAA, 1'b1, 1'b0));
    tbl.push_back(mk(201, '0, 1'b1, 8'h3C, 1'b1, 1'b0));
    tbl.push_back(mk(202, '0, 1'b0, 8'h3C, 1'b1, 1'b0));
    run_seq("t2", 202, 16'hAA3C, -1, 200, 1 << 30);

    // 3: stop mid-word, then restart.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(50, '0, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(51, '1, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(60, '1, 1'b0, 8'h00, 1'b0, 1'b0));
    run_seq("t3a", 60, 16'hAAAA, 50, 0, 1 << 30);
    tbl.delete();
    tbl.push_back(mk(1,  '0, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(80, '0, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(81, '0, 1'b1, 8'h5A, 1'b1, 1'b0));
    run_seq("t3b", 81, 16'h5A00, -1, 0, 1 << 30);

    // 4: constant zero stream trips the repetition test; word held so out_valid must drop.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(81,  '0, 1'b1, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(144, '0, 1'b1, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(145, '1, 1'b0, 8'h00, 1'b0, 1'b1));
    run_seq("t4", 150, 16'h0000, -1, 0, 81);
    tick(); cyc = 151; start = 1'b1;
    tick(); cyc = 152; start = 1'b0; stop = 1'b1;
    check_vec("t4.start_ignored", mk(152, '1, 1'b0, 8'h00, 1'b0, 1'b1));
    tick(); cyc = 153; stop = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    cyc = 173;
    check_vec("t4.stuck", mk(173, '1, 1'b0, 8'h00, 1'b0, 1'b1));
    do_reset();
    check_vec("t4.reset", mk(0, '1, 1'b0, 8'h00, 1'b0, 1'b0));

    // 5: start and stop together in IDLE.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(1,  '1, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(30, '1, 1'b0, 8'h00, 1'b0, 1'b0));
    run_seq("t5", 30, 16'hAAAA, 0, 0, 1 << 30);

    // 6: reset while holding a second word with out_valid high.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(150, '0, 1'b1, 8'hAA, 1'b1, 1'b0));
    run_seq("t6", 150, 16'hAA3C, -1, 1 << 30, 1 << 30);
    chk("t6.state_hold", 64'(dut.state_q), 64'(StHold));
    reset = 1'b1;
    tick(); cyc = 151;
    check_vec("t6.reset", mk(151, '1, 1'b0, 8'h00, 1'b0, 1'b0));
    reset = 1'b0;

    // Randomized run against the model.
    do_reset();
    run_random(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
